// File: rtl/tile_hist_scheduler.sv
// tile_hist_scheduler: frame-level controller for the tile histogram path.
// Walks tiles in raster order: load -> clear -> histogram -> handoff.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_start         pulse, starts a frame (IDLE only)
//   load_req/load_done  tile loader request / completion pulse
//   hist_clear          one-cycle histogram clear pulse
//   hist_start          held while the histogram computes
//   hist_completed      sticky completion flag from the histogram
//   tile_x, tile_y      current tile indices
//   tile_valid/ready    handoff handshake to the CDF/mapping stage
//   busy                controller not idle
//   frame_done          pulse after the last tile handoff
//   timeout_err         sticky abort flag, cleared by an accepted frame_start
module tile_hist_scheduler #(
    parameter int IMG_W   = 360,
    parameter int IMG_H   = 360,
    parameter int TILE    = 45,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic       load_req,
    input  logic       load_done,
    output logic       hist_clear,
    output logic       hist_start,
    input  logic       hist_completed,
    output logic [7:0] tile_x,
    output logic [7:0] tile_y,
    output logic       tile_valid,
    input  logic       tile_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam int NTX = IMG_W / TILE;
    localparam int NTY = IMG_H / TILE;
    localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [7:0]    X_LAST   = 8'(NTX - 1);
    localparam logic [7:0]    Y_LAST   = 8'(NTY - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if (NTX < 1 || NTX > 256 || NTY < 1 || NTY > 256) begin : g_bad_grid
        $error("tile_hist_scheduler: tile grid must be 1..256 per axis");
    end
    if ((IMG_W % TILE) != 0 || (IMG_H % TILE) != 0) begin : g_bad_tile
        $error("tile_hist_scheduler: image size must be a multiple of TILE");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("tile_hist_scheduler: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_HIST,
        S_HANDOFF,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;
    logic          clr_done;
    logic          expired;
    logic          counting;
    logic          abort;
    logic          advance;
    logic          last_col;
    logic          last_row;

    assign last_col = (tile_x == X_LAST);
    assign last_row = (tile_y == Y_LAST);
    assign expired  = (wait_cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        counting = 1'b0;
        abort    = 1'b0;
        advance  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                counting = 1'b1;
                if (load_done) state_nx = S_CLEAR;
                else if (expired) abort = 1'b1;
            end
            S_CLEAR: begin
                // The pulse cycle sees the stale flag of the previous
                // tile, so the completion flag is only judged afterwards.
                if (clr_done) begin
                    counting = 1'b1;
                    if (!hist_completed) state_nx = S_HIST;
                    else if (expired) abort = 1'b1;
                end
            end
            S_HIST: begin
                counting = 1'b1;
                if (hist_completed) state_nx = S_HANDOFF;
                else if (expired) abort = 1'b1;
            end
            S_HANDOFF: begin
                if (tile_ready) begin
                    advance  = 1'b1;
                    state_nx = (last_col && last_row) ? S_DONE : S_LOAD;
                end else begin
                    counting = 1'b1;
                    if (expired) abort = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            clr_done    <= 1'b0;
            tile_x      <= '0;
            tile_y      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            // Low only on the first cycle spent in CLEAR.
            clr_done <= (state == S_CLEAR);
            if (state_nx != state) wait_cnt <= '0;
            else if (counting) wait_cnt <= wait_cnt + 1'b1;
            if (abort) timeout_err <= 1'b1;
            if (state == S_IDLE && frame_start) begin
                tile_x      <= '0;
                tile_y      <= '0;
                timeout_err <= 1'b0;
            end
            if (advance) begin
                if (!last_col) begin
                    tile_x <= tile_x + 8'd1;
                end else if (!last_row) begin
                    tile_x <= '0;
                    tile_y <= tile_y + 8'd1;
                end
            end
        end
    end

    assign load_req   = (state == S_LOAD);
    assign hist_clear = (state == S_CLEAR) && !clr_done;
    assign hist_start = (state == S_HIST);
    assign tile_valid = (state == S_HANDOFF);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

endmodule
